// File: rtl/byte_scan_ctrl.sv
// byte_scan_ctrl: captures a 128-bit word and scans its 16 byte lanes, one per cycle,
// reporting the largest and smallest lane values with their lowest indices.
module byte_scan_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] data_in,
  output logic         busy,
  output logic [3:0]   sel,
  output logic         done,
  output logic [7:0]   max_val,
  output logic [3:0]   max_idx,
  output logic [7:0]   min_val,
  output logic [3:0]   min_idx
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t       state;
  logic [127:0] cap;
  logic [7:0]   lane, wmax, wmin, nmax, nmin;
  logic [3:0]   wmax_idx, wmin_idx, nmax_idx, nmin_idx;
  logic         armed, up_max, up_min;
  assign lane = cap[{sel, 3'b000} +: 8];
  assign busy = state != IDLE;
  assign done = state == DONE;
  // Lane 0 seeds the running extremes; strict compares keep the lowest index on ties.
  always_comb begin
    up_max   = (sel == 4'd0) || (lane > wmax);
    up_min   = (sel == 4'd0) || (lane < wmin);
    nmax     = up_max ? lane : wmax;
    nmax_idx = up_max ? sel : wmax_idx;
    nmin     = up_min ? lane : wmin;
    nmin_idx = up_min ? sel : wmin_idx;
  end
  // armed blocks a start on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      armed    <= 1'b0;
      cap      <= '0;
      sel      <= '0;
      wmax     <= '0;
      wmin     <= '0;
      wmax_idx <= '0;
      wmin_idx <= '0;
      max_val  <= '0;
      max_idx  <= '0;
      min_val  <= '0;
      min_idx  <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: if (start && !abort && armed) begin
          state <= SCAN;
          cap   <= data_in;
          sel   <= '0;
        end
        SCAN: if (abort) begin
          state <= IDLE;
          sel   <= '0;
        end else begin
          wmax     <= nmax;
          wmax_idx <= nmax_idx;
          wmin     <= nmin;
          wmin_idx <= nmin_idx;
          if (sel == 4'd15) begin
            state   <= DONE;
            sel     <= '0;
            max_val <= nmax;
            max_idx <= nmax_idx;
            min_val <= nmin;
            min_idx <= nmin_idx;
          end else begin
            sel <= sel + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_byte_scan_ctrl.sv
// tb_byte_scan_ctrl: directed checks of byte_scan_ctrl timing, extremes, abort and reset.
module tb_byte_scan_ctrl;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [127:0] data_in = '0;
  logic         busy, done;
  logic [3:0]   sel, max_idx, min_idx;
  logic [7:0]   max_val, min_val;
  int checks = 0, errors = 0;
  logic [127:0] d_ramp, d_aa, d_mix;

  byte_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .data_in(data_in),
    .busy(busy), .sel(sel), .done(done),
    .max_val(max_val), .max_idx(max_idx), .min_val(min_val), .min_idx(min_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic results(input string tag, input logic [7:0] mx, input logic [3:0] mxi,
                         input logic [7:0] mn, input logic [3:0] mni);
    chk({tag, "_max_val"}, 32'(max_val), 32'(mx));
    chk({tag, "_max_idx"}, 32'(max_idx), 32'(mxi));
    chk({tag, "_min_val"}, 32'(min_val), 32'(mn));
    chk({tag, "_min_idx"}, 32'(min_idx), 32'(mni));
  endtask

  // Full scan from an idle cycle: start at T, checks T+1..T+18.
  // inj=1 pulses start at T+5 and corrupts data_in at T+3; dstart=1 pulses start at T+17.
  task automatic scan(input string tag, input logic [127:0] d, input bit inj, input bit dstart,
                      input logic [7:0] mx, input logic [3:0] mxi,
                      input logic [7:0] mn, input logic [3:0] mni);
    data_in = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (inj && i == 2) data_in = ~d;
      start = inj && i == 4;
      chk({tag, "_sel"}, 32'(sel), i);
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_done_early"}, 32'(done), 0);
      tick();
    end
    start = dstart;
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy_done"}, 32'(busy), 1);
    chk({tag, "_sel_done"}, 32'(sel), 0);
    results(tag, mx, mxi, mn, mni);
    tick();
    start = 1'b0;
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_done_after"}, 32'(done), 0);
    results({tag, "_hold"}, mx, mxi, mn, mni);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) d_ramp[8*k +: 8] = 8'(k);
    d_aa = {16{8'hAA}};
    d_mix = {16{8'h80}};
    d_mix[8*7 +: 8] = 8'hFF;
    d_mix[8*12 +: 8] = 8'h01;

    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sel", 32'(sel), 0);
    results("rst", 8'h00, 4'd0, 8'h00, 4'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    scan("ramp", d_ramp, 1'b0, 1'b0, 8'h0F, 4'd15, 8'h00, 4'd0);
    scan("aa", d_aa, 1'b0, 1'b1, 8'hAA, 4'd0, 8'hAA, 4'd0);

    data_in = d_ramp;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("abort_sel", 32'(sel), 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_sel0", 32'(sel), 0);
    for (int i = 0; i < 14; i++) begin
      chk("abort_no_done", 32'(done), 0);
      tick();
    end
    results("abort", 8'hAA, 4'd0, 8'hAA, 4'd0);

    scan("inject", d_ramp, 1'b1, 1'b0, 8'h0F, 4'd15, 8'h00, 4'd0);
    scan("mix", d_mix, 1'b0, 1'b0, 8'hFF, 4'd7, 8'h01, 4'd12);

    data_in = d_aa;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("rst_mid_sel", 32'(sel), 9);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_done", 32'(done), 0);
    chk("rst_mid_sel0", 32'(sel), 0);
    results("rst_mid", 8'h00, 4'd0, 8'h00, 4'd0);
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    data_in = d_mix;
    tick();
    start = 1'b0;
    chk("rst_release_ignored", 32'(busy), 0);
    for (int i = 0; i < 20; i++) begin
      chk("rst_no_done", 32'(done), 0);
      tick();
    end
    scan("post_rst", d_mix, 1'b0, 1'b0, 8'hFF, 4'd7, 8'h01, 4'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/byte_scan_ctrl.md
BYTE_SCAN_CTRL -- requirements
Module: byte_scan_ctrl

Interface
REQ-001 Parameters: none; fixed 16 lanes x 8 bits (128-bit word), lane k = data[8k+7:8k].
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to scan data_in; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of an in-progress scan.
REQ-006 data_in  input  128  word to scan; captured on accepted start.
REQ-007 busy  output  1  high whenever state != IDLE.
REQ-008 sel  output  4  current lane index driving the internal 16-to-1 byte selector.
REQ-009 done  output  1  one-cycle pulse, results valid.
REQ-010 max_val  output  8  largest lane value of last completed scan.
REQ-011 max_idx  output  4  lane index of max_val.
REQ-012 min_val  output  8  smallest lane value of last completed scan.
REQ-013 min_idx  output  4  lane index of min_val.

Function
REQ-014 The block SHALL contain a 128-bit capture register feeding an internal 16-to-1 byte selector whose select is sel; the selector stays combinational, all sequencing lives in this block.
REQ-015 FSM states SHALL be IDLE, SCAN, DONE; IDLE->SCAN on start=1; SCAN->DONE when sel==15 is processed; DONE->IDLE unconditionally next cycle.
REQ-016 On accepted start (cycle T) the block SHALL capture data_in and set sel=0; data_in is ignored thereafter until the next accepted start.
REQ-017 SCAN SHALL process exactly one lane per cycle, sel = 0..15 on cycles T+1..T+16, incrementing by 1 with no wrap inside a scan.
REQ-018 At sel==0 the working max/min SHALL be initialised to lane 0 value with indices 0.
REQ-019 At sel>0 working max SHALL update only if lane > working max (strict, unsigned); working min only if lane < working min (strict, unsigned); ties keep the lowest index.
REQ-020 Results SHALL be transferred to max_val/max_idx/min_val/min_idx on the SCAN->DONE edge, including lane 15's comparison, so they are valid in the done cycle (T+17).
REQ-021 done SHALL be high only in DONE, exactly one cycle, at T+17; busy SHALL be high T+1..T+17 inclusive and low at T+18.
REQ-022 Result outputs SHALL hold their values from DONE until the next completed scan.
REQ-023 start while busy SHALL be ignored (no restart, no capture).
REQ-024 abort=1 in SCAN or DONE SHALL force IDLE on the next edge, suppress done if not yet asserted, and leave result outputs unchanged; abort in IDLE has no effect; abort has priority over start.
REQ-025 start asserted in the same cycle DONE is active SHALL be ignored; a new start is accepted from T+18 onward (back-to-back scans every 18 cycles maximum rate).
REQ-026 sel SHALL read 0 in IDLE and DONE.

Reset
REQ-027 rst_n=0 SHALL immediately (no clock) force state IDLE, busy=0, done=0, sel=0, all result outputs 0, capture and working registers 0.
REQ-028 Reset asserted mid-scan SHALL discard the scan; after release the block SHALL wait for a fresh start.
REQ-029 Release of rst_n SHALL be treated as synchronous to clk; no start is accepted in the cycle rst_n deasserts.

Verification
REQ-030 Lane k = k (0x00..0x0F), start at T -> done at T+17 only, max_val=0x0F max_idx=15, min_val=0x00 min_idx=0, busy low at T+18.
REQ-031 All lanes 0xAA -> max_val=min_val=0xAA, max_idx=min_idx=0 (tie rule).
REQ-032 All lanes 0x80 except lane7=0xFF, lane12=0x01 -> max 0xFF/7, min 0x01/12; sel observed 0..15 on T+1..T+16.
REQ-033 Start pulsed at T+5 and data_in changed at T+3 during scan of REQ-030 data -> no restart, results identical to REQ-030.
REQ-034 After REQ-031 completes, new scan aborted at sel==5 -> busy low next cycle, no done pulse, outputs still 0xAA/0/0xAA/0; subsequent start completes normally.
REQ-035 rst_n low at sel==9 -> all outputs 0 asynchronously, no done; after release and start with REQ-032 data, correct results at T+17.
